// File: rtl/preg_free_list_ctrl.sv
// Physical-register free list (circular FIFO) plus per-preg ready scoreboard for rename/issue.
// Latency: grant and readiness are combinational; the list and the ready bits update on the next edge.
// Backpressure: alloc_gnt drops while the list is empty; a free into a full list is dropped and flagged.
module preg_free_list_ctrl #(
    parameter int NUM_PREGS  = 64,
    parameter int NUM_AREGS  = 32,
    parameter int PREG_W     = $clog2(NUM_PREGS),
    parameter int FREE_DEPTH = NUM_PREGS - NUM_AREGS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alloc_req,
    output logic              alloc_gnt,
    output logic [PREG_W-1:0] alloc_preg,
    input  logic              free_valid,
    input  logic [PREG_W-1:0] free_preg,
    input  logic              wb_valid,
    input  logic [PREG_W-1:0] wb_preg,
    input  logic [PREG_W-1:0] ps1,
    input  logic [PREG_W-1:0] ps2,
    output logic              ps1_ready,
    output logic              ps2_ready,
    output logic [PREG_W-1:0] free_count,
    output logic              overflow_err
);

    localparam int PTR_W = $clog2(FREE_DEPTH);
    localparam int CNT_W = $clog2(FREE_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FREE_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FREE_DEPTH - 1);

    logic [PREG_W-1:0]    entries_q [FREE_DEPTH];
    logic [PREG_W-1:0]    entries_d [FREE_DEPTH];
    logic [PTR_W-1:0]     head_q, head_d;
    logic [PTR_W-1:0]     tail_q, tail_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [NUM_PREGS-1:0] ready_q, ready_d;
    logic                 overflow_q, overflow_d;

    logic free_ok;
    logic push;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign alloc_gnt    = alloc_req && (count_q != '0);
    assign alloc_preg   = entries_q[head_q];
    assign free_count   = PREG_W'(count_q);
    assign overflow_err = overflow_q;

    // p0 is hardwired to x0; a same-cycle writeback is bypassed to the query.
    assign ps1_ready = (ps1 == '0) || ready_q[ps1] || (wb_valid && (wb_preg == ps1));
    assign ps2_ready = (ps2 == '0) || ready_q[ps2] || (wb_valid && (wb_preg == ps2));

    always_comb begin
        entries_d  = entries_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        ready_d    = ready_q;
        overflow_d = overflow_q;

        free_ok = free_valid && (free_preg != '0);
        push    = free_ok && (count_q != FULL_CNT);

        if (free_ok && (count_q == FULL_CNT)) begin
            overflow_d = 1'b1;
        end

        if (push) begin
            entries_d[tail_q] = free_preg;
            tail_d            = ptr_inc(tail_q);
        end

        if (alloc_gnt) begin
            head_d = ptr_inc(head_q);
        end

        if (push && !alloc_gnt) begin
            count_d = count_q + 1'b1;
        end else if (alloc_gnt && !push) begin
            count_d = count_q - 1'b1;
        end

        // Allocation is applied after writeback so a fresh mapping always starts not-ready.
        if (wb_valid) begin
            ready_d[wb_preg] = 1'b1;
        end
        if (alloc_gnt) begin
            ready_d[alloc_preg] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FREE_DEPTH; i++) begin
                entries_q[i] <= PREG_W'(NUM_AREGS + i);
            end
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= FULL_CNT;
            ready_q    <= '1;
            overflow_q <= 1'b0;
        end else begin
            entries_q  <= entries_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            ready_q    <= ready_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_preg_free_list_ctrl.sv
// Directed plus randomized bench for preg_free_list_ctrl against a queue-history reference model.
module tb_preg_free_list_ctrl;

    localparam int NP    = 64;
    localparam int NA    = 32;
    localparam int DEPTH = NP - NA;

    logic       clk;
    logic       reset;
    logic       alloc_req;
    logic       alloc_gnt;
    logic [5:0] alloc_preg;
    logic       free_valid;
    logic [5:0] free_preg;
    logic       wb_valid;
    logic [5:0] wb_preg;
    logic [5:0] ps1;
    logic [5:0] ps2;
    logic       ps1_ready;
    logic       ps2_ready;
    logic [5:0] free_count;
    logic       overflow_err;

    preg_free_list_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .alloc_req    (alloc_req),
        .alloc_gnt    (alloc_gnt),
        .alloc_preg   (alloc_preg),
        .free_valid   (free_valid),
        .free_preg    (free_preg),
        .wb_valid     (wb_valid),
        .wb_preg      (wb_preg),
        .ps1          (ps1),
        .ps2          (ps2),
        .ps1_ready    (ps1_ready),
        .ps2_ready    (ps2_ready),
        .free_count   (free_count),
        .overflow_err (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: every value ever enqueued, in order; the list is hist[pops .. end].
    // Ring slots are reused every DEPTH writes, so an empty list exposes hist[pops-DEPTH].
    int      hist[$];
    int      pops;
    bit      rdy[NP];
    bit      ovf;
    bit      mvalid;

    int n_cmp;
    int n_err;

    task automatic cmp(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int m_count();
        return hist.size() - pops;
    endfunction

    function automatic int m_head();
        return (m_count() > 0) ? hist[pops] : hist[pops - DEPTH];
    endfunction

    function automatic int m_ready(input int p);
        return ((p == 0) || rdy[p] || (wb_valid && (int'(wb_preg) == p))) ? 1 : 0;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < DEPTH; i++) hist.push_back(NA + i);
        pops = 0;
        for (int i = 0; i < NP; i++) rdy[i] = 1'b1;
        ovf    = 1'b0;
        mvalid = 1'b1;
    endtask

    task automatic model_update();
        int  cnt;
        int  head;
        bit  gnt;
        bit  fok;
        if (reset) begin
            model_reset();
            return;
        end
        cnt  = m_count();
        head = m_head();
        gnt  = alloc_req && (cnt != 0);
        fok  = free_valid && (free_preg != 0);
        if (fok && cnt == DEPTH) ovf = 1'b1;
        if (wb_valid) rdy[wb_preg] = 1'b1;
        if (gnt) begin
            rdy[head] = 1'b0;
            pops++;
        end
        if (fok && cnt != DEPTH) hist.push_back(int'(free_preg));
    endtask

    task automatic check_model();
        int exp_gnt;
        if (!mvalid) return;
        exp_gnt = (alloc_req && m_count() != 0) ? 1 : 0;
        cmp("alloc_gnt",    int'(alloc_gnt),    exp_gnt);
        cmp("alloc_preg",   int'(alloc_preg),   m_head());
        cmp("free_count",   int'(free_count),   m_count());
        cmp("overflow_err", int'(overflow_err), ovf ? 1 : 0);
        cmp("ps1_ready",    int'(ps1_ready),    m_ready(int'(ps1)));
        cmp("ps2_ready",    int'(ps2_ready),    m_ready(int'(ps2)));
    endtask

    task automatic settle();
        @(negedge clk);
        check_model();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_update();
    endtask

    task automatic step();
        settle();
        tick();
    endtask

    initial begin
        int pa;
        int pf;
        n_cmp = 0;
        n_err = 0;
        mvalid = 1'b0;
        reset = 1'b1; alloc_req = 1'b0; free_valid = 1'b0; free_preg = '0;
        wb_valid = 1'b0; wb_preg = '0; ps1 = 6'd45; ps2 = 6'd0;
        step();
        step();
        reset = 1'b0;

        // Reset values
        settle();
        cmp("rst_preg", int'(alloc_preg), 32);
        cmp("rst_cnt", int'(free_count), 32);
        cmp("rst_ovf", int'(overflow_err), 0);
        cmp("rst_rdy", int'(ps1_ready), 1);
        tick();

        // Three allocations in order
        alloc_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            settle();
            cmp("a3_gnt", int'(alloc_gnt), 1);
            cmp("a3_preg", int'(alloc_preg), 32 + k);
            tick();
        end
        alloc_req = 1'b0; ps1 = 6'd33;
        settle();
        cmp("a3_cnt", int'(free_count), 29);
        cmp("a3_ps1", int'(ps1_ready), 0);
        tick();

        // Drain to empty, then stall
        alloc_req = 1'b1;
        for (int k = 0; k < 29; k++) begin
            settle();
            if (k == 28) cmp("a32_last", int'(alloc_preg), 63);
            tick();
        end
        settle();
        cmp("empty_cnt", int'(free_count), 0);
        cmp("empty_gnt", int'(alloc_gnt), 0);
        cmp("empty_preg", int'(alloc_preg), 32);
        tick();
        settle();
        cmp("empty_preg2", int'(alloc_preg), 32);
        tick();

        // No same-cycle bypass from free to alloc
        free_valid = 1'b1; free_preg = 6'd5;
        settle();
        cmp("nobyp_gnt", int'(alloc_gnt), 0);
        tick();
        free_valid = 1'b0;
        settle();
        cmp("fr5_gnt", int'(alloc_gnt), 1);
        cmp("fr5_preg", int'(alloc_preg), 5);
        tick();
        alloc_req = 1'b0;
        settle();
        cmp("fr5_cnt", int'(free_count), 0);
        tick();

        // Walk pointers forward so the half-full fill wraps past the last slot
        free_valid = 1'b1; free_preg = 6'd9;
        step();
        alloc_req = 1'b1;
        repeat (24) step();
        alloc_req = 1'b0;
        for (int k = 0; k < 15; k++) begin
            free_preg = 6'(11 + k);
            step();
        end
        free_preg = 6'd7; alloc_req = 1'b1;
        settle();
        cmp("half_gnt", int'(alloc_gnt), 1);
        tick();
        free_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            settle();
            if (k == 0) cmp("half_cnt", int'(free_count), 16);
            if (k == 15) cmp("fifo_last", int'(alloc_preg), 7);
            tick();
        end
        alloc_req = 1'b0;

        // Writeback bypass and alloc-wins-over-writeback
        ps2 = 6'd40;
        settle();
        cmp("rdy40_pre", int'(ps2_ready), 0);
        tick();
        wb_valid = 1'b1; wb_preg = 6'd40;
        settle();
        cmp("byp40", int'(ps2_ready), 1);
        tick();
        wb_valid = 1'b0;
        settle();
        cmp("rdy40_hold", int'(ps2_ready), 1);
        tick();
        free_valid = 1'b1; free_preg = 6'd40;
        step();
        free_valid = 1'b0;
        alloc_req = 1'b1; wb_valid = 1'b1; wb_preg = 6'd40;
        settle();
        cmp("aw_preg", int'(alloc_preg), 40);
        tick();
        alloc_req = 1'b0; wb_valid = 1'b0;
        settle();
        cmp("aw_rdy", int'(ps2_ready), 0);
        tick();

        // Overflow, p0 free ignored, mid-run reset
        reset = 1'b1;
        step();
        reset = 1'b0;
        free_valid = 1'b1; free_preg = 6'd10;
        settle();
        cmp("ovf_pre", int'(overflow_err), 0);
        tick();
        free_valid = 1'b0;
        settle();
        cmp("ovf_set", int'(overflow_err), 1);
        cmp("ovf_cnt", int'(free_count), 32);
        cmp("ovf_preg", int'(alloc_preg), 32);
        tick();
        alloc_req = 1'b1;
        step();
        alloc_req = 1'b0;
        free_valid = 1'b1; free_preg = 6'd0;
        step();
        free_valid = 1'b0;
        settle();
        cmp("p0_cnt", int'(free_count), 31);
        cmp("ovf_sticky", int'(overflow_err), 1);
        tick();
        reset = 1'b1;
        step();
        reset = 1'b0;
        settle();
        cmp("rst2_cnt", int'(free_count), 32);
        cmp("rst2_preg", int'(alloc_preg), 32);
        cmp("rst2_ovf", int'(overflow_err), 0);
        tick();

        // Randomized phases with varying alloc/free pressure
        for (int i = 0; i < 4000; i++) begin
            case ((i / 400) % 4)
                0:       begin pa = 80; pf = 20; end
                1:       begin pa = 20; pf = 85; end
                2:       begin pa = 50; pf = 50; end
                default: begin pa = 95; pf = 95; end
            endcase
            reset      = ($urandom_range(0, 999) == 0);
            alloc_req  = ($urandom_range(0, 99) < pa);
            free_valid = ($urandom_range(0, 99) < pf);
            free_preg  = 6'($urandom_range(0, 63));
            wb_valid   = ($urandom_range(0, 99) < 40);
            wb_preg    = 6'($urandom_range(0, 63));
            ps1        = ($urandom_range(0, 3) == 0) ? wb_preg : 6'($urandom_range(0, 63));
            ps2        = ($urandom_range(0, 3) == 0) ? 6'(m_head()) : 6'($urandom_range(0, 63));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
